// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared definitions for the UART controllers
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx
);

    // Scan offsets from the far end back toward ptr so the nearest request wins last
    always_comb begin
        int k;
        logic [IDX_W-1:0] kk;
        pick     = '0;
        pick_idx = '0;
        k        = 0;
        kk       = '0;
        for (int off = N - 1; off >= 0; off--) begin
            k = int'(ptr) + off;
            if (k >= N) begin
                k = k - N;
            end
            kk = IDX_W'(k);
            if (req[kk]) begin
                pick     = '0;
                pick[kk] = 1'b1;
                pick_idx = kk;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin packet arbiter for the uart_fifo TX port
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]         tx_byte,
    output logic                      transmit,
    input  logic                      tx_fifo_full,
    output logic                      arb_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e          state;
    logic [IDX_W-1:0]    gidx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    idle_cnt;

    logic [NUM_REQ-1:0]  pick;
    logic [IDX_W-1:0]    pick_idx;
    logic                g_valid;
    logic                g_last;
    logic [BYTE_W-1:0]   g_data;
    logic                accept;
    logic [IDX_W-1:0]    next_ptr;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign g_valid  = req_valid[gidx];
    assign g_last   = req_last[gidx];
    assign g_data   = req_data[gidx*BYTE_W +: BYTE_W];
    // The !transmit term spaces pushes two cycles apart, absorbing the FIFO full-flag lag
    assign accept   = (state == ST_LOCK) & g_valid & ~tx_fifo_full & ~transmit;
    assign next_ptr = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    // Only the owner of the grant can see ready
    always_comb begin
        req_ready       = '0;
        req_ready[gidx] = accept;
    end

    // Arbitration FSM with packet lock, idle watchdog and registered push outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            gidx        <= '0;
            rr_ptr      <= '0;
            idle_cnt    <= '0;
            transmit    <= 1'b0;
            tx_byte     <= '0;
            arb_timeout <= 1'b0;
        end else begin
            transmit    <= 1'b0;
            arb_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (|req_valid) begin
                        grant <= pick;
                        gidx  <= pick_idx;
                        state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (accept) begin
                        transmit <= 1'b1;
                        tx_byte  <= g_data;
                    end
                    if (accept && g_last) begin
                        state    <= ST_IDLE;
                        grant    <= '0;
                        rr_ptr   <= next_ptr;
                        idle_cnt <= '0;
                    end else if (g_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
                        // This is the IDLE_TIMEOUT-th silent cycle: revoke the grant
                        state       <= ST_IDLE;
                        grant       <= '0;
                        rr_ptr      <= next_ptr;
                        idle_cnt    <= '0;
                        arb_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_byte;
    logic           transmit;
    logic           tx_fifo_full;
    logic           arb_timeout;

    uart_tx_arb #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .tx_byte      (tx_byte),
        .transmit     (transmit),
        .tx_fifo_full (tx_fifo_full),
        .arb_timeout  (arb_timeout)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [8:0] src_q[N][$];
    logic [7:0] exp_q[$];
    int         tx_cyc[$];
    int         glog_idx[$];
    int         glog_cyc[$];
    int         to_cyc[$];
    logic [N-1:0] en = '1;
    logic [N-1:0] acc_s = '0;
    logic       prev_tx = 1'b0;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: expected push stream, ready rule, one-hot grant, push spacing
    always @(negedge clk) begin
        logic [N-1:0] er;
        acc_s = req_ready & req_valid;
        if (transmit) begin
            tx_cyc.push_back(cyc);
            if (exp_q.size() == 0) fail_now("spurious_push");
            else chk("push_byte", int'(tx_byte), int'(exp_q.pop_front()));
            chk("push_spacing", int'(prev_tx), 0);
        end
        er = '0;
        for (int i = 0; i < N; i++)
            if (grant[i] && req_valid[i] && !tx_fifo_full && !transmit) er[i] = 1'b1;
        chk("req_ready", int'(req_ready), int'(er));
        chk("grant_onehot0", int'($countones(grant) <= 1), 1);
        if (grant != '0 && grant != prev_grant) begin
            for (int i = 0; i < N; i++) if (grant[i]) glog_idx.push_back(i);
            glog_cyc.push_back(cyc);
        end
        if (arb_timeout) to_cyc.push_back(cyc);
        prev_tx    = transmit;
        prev_grant = grant;
    end

    // Requester models: offer the head of each queue, pop on handshake
    initial begin
        logic [8:0] e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++)
                if (acc_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            #1;
            for (int i = 0; i < N; i++) begin
                if (en[i] && src_q[i].size() > 0) begin
                    e = src_q[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = e[7:0];
                    req_last[i]        = e[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    task automatic push_pkt(input int r, input int base, input int len);
        for (int k = 0; k < len; k++)
            src_q[r].push_back({(k == len - 1), 8'(base + k)});
    endtask

    task automatic push_exp(input int base, input int len);
        for (int k = 0; k < len; k++) exp_q.push_back(8'(base + k));
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        tx_cyc.delete(); glog_idx.delete(); glog_cyc.delete(); to_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && grant == '0 && src_empty() && !transmit) return;
        end
        fail_now(name);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        int seen;
        int stall_tx;
        int stall_rdy;
        bit found;
        int fair_exp[5];
        fair_exp = '{0, 1, 2, 3, 0};
        tx_fifo_full = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_transmit", int'(transmit), 0);
        chk("rst_tx_byte", int'(tx_byte), 0);
        chk("rst_arb_timeout", int'(arb_timeout), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single packet from requester 2
        clear_logs();
        @(posedge clk);
        push_pkt(2, 'h41, 3);
        push_exp('h41, 3);
        #2 t0 = cyc;
        @(negedge clk);
        chk("arb_pre_grant", int'(grant), 0);
        @(negedge clk);
        chk("arb_grant", int'(grant), 'b0100);
        chk("arb_ready", int'(req_ready), 'b0100);
        wait_idle("single_drain");
        chk("single_push_count", tx_cyc.size(), 3);
        if (tx_cyc.size() == 3) begin
            chk("single_first_push_lat", tx_cyc[0] - t0, 2);
            chk("single_spacing_1", tx_cyc[1] - tx_cyc[0], 2);
            chk("single_spacing_2", tx_cyc[2] - tx_cyc[1], 2);
        end
        chk("single_grant_count", glog_idx.size(), 1);
        if (glog_idx.size() == 1) chk("single_grant_idx", glog_idx[0], 2);

        // Fairness across all four requesters
        do_reset();
        clear_logs();
        @(posedge clk);
        push_pkt(0, 'hA0, 2); push_pkt(1, 'hB0, 2); push_pkt(2, 'hC0, 2);
        push_pkt(3, 'hD0, 2); push_pkt(0, 'hE0, 2);
        push_exp('hA0, 2); push_exp('hB0, 2); push_exp('hC0, 2);
        push_exp('hD0, 2); push_exp('hE0, 2);
        wait_idle("fair_drain");
        chk("fair_grant_count", glog_idx.size(), 5);
        if (glog_idx.size() == 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("fair_order_%0d", k), glog_idx[k], fair_exp[k]);
            for (int k = 0; k < 4; k++) chk($sformatf("fair_b2b_%0d", k), glog_cyc[k+1] - glog_cyc[k], 4);
        end

        // Back-pressure for 10 cycles mid-packet
        clear_logs();
        @(posedge clk);
        push_pkt(1, 'h51, 5);
        push_exp('h51, 5);
        seen = 0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            @(negedge clk);
            if (transmit) seen++;
        end
        chk("bp_reach_second_push", seen, 2);
        @(posedge clk); #1 tx_fifo_full = 1'b1;
        stall_tx = 0;
        stall_rdy = 0;
        repeat (10) begin
            @(negedge clk);
            if (transmit) stall_tx++;
            if (req_ready != '0) stall_rdy++;
        end
        chk("bp_no_transmit", stall_tx, 0);
        chk("bp_no_ready", stall_rdy, 0);
        @(posedge clk); #1 tx_fifo_full = 1'b0;
        wait_idle("bp_drain");
        chk("bp_push_count", tx_cyc.size(), 5);
        if (tx_cyc.size() == 5) chk("bp_stall_gap", tx_cyc[2] - tx_cyc[1], 12);
        chk("bp_no_timeout", to_cyc.size(), 0);

        // Idle timeout with another requester pending
        do_reset();
        clear_logs();
        @(posedge clk);
        src_q[1].push_back({1'b0, 8'h10});
        exp_q.push_back(8'h10);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (grant == 4'b0010) found = 1'b1;
        end
        chk("to_grant1_seen", int'(found), 1);
        push_pkt(2, 'h20, 2);
        push_exp('h20, 2);
        wait_idle("to_drain");
        chk("to_pulse_count", to_cyc.size(), 1);
        chk("to_push_count", tx_cyc.size(), 3);
        if (to_cyc.size() == 1 && tx_cyc.size() == 3)
            chk("to_idle_cycles", to_cyc[0] - tx_cyc[0], 8);
        chk("to_grant_count", glog_idx.size(), 2);
        if (glog_idx.size() == 2 && to_cyc.size() == 1) begin
            chk("to_next_owner", glog_idx[1], 2);
            chk("to_regrant_lat", glog_cyc[1] - to_cyc[0], 1);
        end

        // Reset in the middle of a packet
        clear_logs();
        @(posedge clk);
        push_pkt(3, 'h70, 4);
        exp_q.push_back(8'h70);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (transmit) found = 1'b1;
        end
        chk("mid_rst_push_seen", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_transmit", int'(transmit), 0);
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_tx_byte", int'(tx_byte), 0);
        exp_q.delete();
        push_pkt(0, 'h80, 2);
        push_exp('h80, 2);
        push_exp('h71, 3);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_idle("mid_rst_drain");
        chk("mid_rst_grant_count", glog_idx.size(), 3);
        if (glog_idx.size() == 3) begin
            chk("mid_rst_first_after", glog_idx[1], 0);
            chk("mid_rst_second_after", glog_idx[2], 3);
        end

        // Last byte accepted while another requester rises
        clear_logs();
        en[2] = 1'b0;
        @(posedge clk);
        push_pkt(1, 'h90, 2);
        push_pkt(2, 'hA5, 1);
        push_exp('h90, 2);
        push_exp('hA5, 1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (transmit && tx_byte == 8'h90) found = 1'b1;
        end
        chk("sim_first_push_seen", int'(found), 1);
        en[2] = 1'b1;
        @(negedge clk);
        chk("sim_last_ready", int'(req_ready), 'b0010);
        chk("sim_last_flag", int'(req_last[1] & req_ready[1]), 1);
        @(negedge clk);
        chk("sim_idle_gap", int'(grant), 0);
        @(negedge clk);
        chk("sim_new_grant", int'(grant), 'b0100);
        wait_idle("sim_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
